wrap_counter: RTL
=================

WRAP_COUNTER -- requirements
Module: wrap_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 10: count/max/load_value width, legal 2..16.
REQ-002 SHALL have parameter DEBOUNCE_BITS, default 16: debounce stability counter width, legal 1..24.
REQ-003 SHALL have port clock  input  1: single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port step  input  1: raw asynchronous step request (push-button level).
REQ-006 SHALL have port dir  input  1: 1 = count up, 0 = count down; synchronous to clock.
REQ-007 SHALL have port max  input  WIDTH: inclusive upper bound of count range 0..max.
REQ-008 SHALL have port load  input  1: synchronous load strobe.
REQ-009 SHALL have port load_value  input  WIDTH: value applied on load.
REQ-010 SHALL have port count  output  WIDTH: registered current count.
REQ-011 SHALL have port wrap  output  1: registered one-cycle pulse on range wrap.

Function
REQ-012 step SHALL pass through a two-flop synchroniser (s1, s2) before any use.
REQ-013 Internal step_pulse SHALL be high for exactly one cycle per conditioned rising edge of step; a held step SHALL never produce more than one pulse.
REQ-014 Priority per cycle: load > step_pulse > hold.
REQ-015 load: count <= min(load_value, max); wrap <= 0; a coincident step_pulse SHALL be discarded.
REQ-016 Up step (dir=1): count >= max -> count <= 0, wrap <= 1; else count <= count+1, wrap <= 0.
REQ-017 Down step (dir=0): count == 0 -> count <= max, wrap <= 1; count > max -> count <= max, wrap <= 0; else count <= count-1, wrap <= 0.
REQ-018 max == 0: count SHALL remain 0 and every step_pulse SHALL assert wrap.
REQ-019 max reduced below current count with no step: count SHALL hold unchanged until next step or load.
REQ-020 wrap SHALL be 0 in every cycle without a qualifying wrap event.
REQ-021 All arithmetic SHALL be WIDTH-bit unsigned; no carry/borrow escapes the range rules above.
REQ-022 count and wrap SHALL update on the clock edge at which step_pulse is high (one edge after pulse generation).

Reset
REQ-023 reset_n low SHALL immediately force count = 0, wrap = 0, synchroniser, edge, and debounce state to 0, independent of clock.
REQ-024 Reset asserted mid-debounce SHALL discard the pending edge; after release, step already high SHALL be treated as a fresh rising edge.
REQ-025 First step_pulse after reset_n deassertion SHALL be no earlier than the 3rd rising clock edge.

Configuration
REQ-026 Macro WRAP_COUNTER_DEBOUNCE_EN SHALL select the step conditioning.
REQ-027 Defined: stable level register; stability counter increments each cycle s2 != stable, clears when s2 == stable; at all-ones with s2 != stable, stable toggles and counter clears; step_pulse is registered, high one cycle after stable goes 0->1.
REQ-028 Defined: a step glitch shorter than 2^DEBOUNCE_BITS cycles SHALL produce no step_pulse; raw-high to count change = 2^DEBOUNCE_BITS + 3 edges.
REQ-029 Not defined: no debounce logic; step_pulse = s2 & ~s3 (s3 = registered s2); raw-high to count change = 3 edges; DEBOUNCE_BITS ignored.

Verification
REQ-030 Up wrap: WIDTH=10, max=5, dir=1, 7 clean steps -> count 1,2,3,4,5,0,1; wrap high one cycle only at 5->0.
REQ-031 Down wrap: max=5, load_value=1 loaded, dir=0, 3 steps -> count 0,5,4; wrap high only at 0->5.
REQ-032 Load priority/clamp: count=3, load=1 with load_value=9, max=5, coincident step_pulse -> count=5, wrap=0, step lost.
REQ-033 Debounce (macro on, DEBOUNCE_BITS=2): 2-cycle high glitch -> no count change; 10-cycle high -> exactly one increment 7 edges after first sampled high.
REQ-034 No-debounce (macro off): step held high 20 cycles -> exactly one increment at edge 3; max=0 -> count stays 0, wrap pulses per step.
REQ-035 Reset mid-operation: count=4, reset_n low between edges -> count=0, wrap=0 without clock edge; step held high through release -> one increment after conditioning latency.

Source files
------------

// File: rtl/wrap_counter.sv
// Bounded up/down wrap counter driven by a synchronised, edge-detected push-button step.
// Define WRAP_COUNTER_DEBOUNCE_EN to insert a stability-counter debouncer ahead of the edge detector.
module wrap_counter #(
   parameter int WIDTH         = 10,
   parameter int DEBOUNCE_BITS = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             step,
   input  logic             dir,
   input  logic [WIDTH-1:0] max,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   logic             s1_q, s2_q;
   logic             step_pulse;
   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= step;
         s2_q <= s2_q ^ (s1_q ^ s2_q);
      end
   end

`ifdef WRAP_COUNTER_DEBOUNCE_EN
   logic                     stable_q, stable_d;
   logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
   logic                     pulse_q, pulse_d;

   // The accepted level flips only after s2 disagrees with it for 2^DEBOUNCE_BITS edges.
   always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      pulse_d  = 1'b0;
      if (s2_q != stable_q) begin
         if (&db_cnt_q) begin
            stable_d = s2_q;
            pulse_d  = s2_q;
         end else begin
            db_cnt_d = db_cnt_q + DEBOUNCE_BITS'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stable_q <= 1'b0;
         db_cnt_q <= '0;
         pulse_q  <= 1'b0;
      end else begin
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
         pulse_q  <= pulse_d;
      end
   end

   assign step_pulse = pulse_q;
`else
   logic s3_q;

   // DEBOUNCE_BITS has no effect in this build; the guard only keeps the parameter referenced.
   if (DEBOUNCE_BITS >= 1) begin : g_edge
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            s3_q <= 1'b0;
         end else begin
            s3_q <= s2_q;
         end
      end
   end

   assign step_pulse = s2_q & ~s3_q;
`endif

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = (load_value > max) ? max : load_value;
      end else if (step_pulse) begin
         if (dir) begin
            if (count_q >= max) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == '0) begin
               count_d = max;
               wrap_d  = 1'b1;
            end else if (count_q > max) begin
               count_d = max;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;

endmodule
